// File: rtl/dds_pkg.sv
// DDS DAC transmit path: shared types and constants.
// Sine table values are built here at elaboration time.
package dds_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOP_PEND
  } state_t;

  localparam int MIDSCALE   = 128;
  localparam int AMP_FULL   = 128;
  localparam int LUT_AW_DEF = 8;
  localparam int LUT_DEPTH  = 1 << LUT_AW_DEF;

  // round(127*sin(2*pi*i/depth)) via quadrant fold and Taylor series
  function automatic int sine_q(input int i, input int depth);
    real pi, x, t, s;
    pi = 3.14159265358979323846;
    x  = 2.0 * pi * real'(i) / real'(depth);
    if (x > pi) x = x - 2.0 * pi;
    if (x > pi / 2.0) x = pi - x;
    else if (x < -pi / 2.0) x = -pi - x;
    t = x;
    s = x;
    for (int k = 1; k < 10; k++) begin
      t = -t * x * x / real'((2 * k) * (2 * k + 1));
      s = s + t;
    end
    return int'(127.0 * s);
  endfunction

endpackage

// File: rtl/dds_dac_tx_sine_rom.sv
// Full-wave signed sine ROM, synchronous read.
// Clock enable advances it; clr loads midscale (zero).
module sine_rom
  import dds_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 clr,
  input  logic [AW-1:0]        addr,
  output logic signed [DW-1:0] q
);

  logic signed [DW-1:0] rom [2**AW];

  for (genvar i = 0; i < 2**AW; i++) begin : g_rom
    localparam logic signed [DW-1:0] V =
      DW'(sine_q(i, 2**AW));
    assign rom[i] = V;
  end

  // registered read, cleared to zero when the path is idle
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= clr ? '0 : rom[addr];
    end
  end

endmodule

// File: rtl/dds_dac_tx.sv
// DDS sine generator driving an 8-bit parallel DAC.
// Sample clock is a divided clk; stages advance on tick.
module dds_dac_tx
  import dds_pkg::*;
#(
  parameter int PHASE_W = 32,
  parameter int LUT_AW  = 8,
  parameter int DATA_W  = 8,
  parameter int DIV_N   = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [PHASE_W-1:0] fword_in,
  input  logic               fword_load,
  input  logic [7:0]         amp,
  output logic [DATA_W-1:0]  DA0,
  output logic               DA0_CLK,
  output logic               sample_tick,
  output logic               running
);

  localparam int CW = (DIV_N > 2) ? $clog2(DIV_N) : 1;
  localparam int PW = DATA_W + 8;

  logic [CW-1:0]        cnt;
  logic [CW-1:0]        cnt_nxt;
  logic                 tick;
  state_t               state;
  state_t               state_nxt;
  logic [PHASE_W-1:0]   acc;
  logic [PHASE_W-1:0]   fw_shadow;
  logic [PHASE_W-1:0]   fw_active;
  logic [PHASE_W:0]     acc_sum;
  logic                 carry;
  logic                 rom_clr;
  logic signed [DATA_W-1:0] rom_q;
  logic [7:0]           amp_c;
  logic signed [PW-1:0] rom_x;
  logic signed [PW-1:0] amp_x;
  logic signed [PW-1:0] prod;
  logic [DATA_W-1:0]    da_nxt;

  assign tick    = (cnt == CW'(DIV_N - 1));
  assign cnt_nxt = tick ? '0 : cnt + 1'b1;
  assign acc_sum = {1'b0, acc} + {1'b0, fw_active};
  assign carry   = acc_sum[PHASE_W];
  assign rom_clr = (state == IDLE);

  assign amp_c  = (amp > 8'(AMP_FULL)) ? 8'(AMP_FULL) : amp;
  assign rom_x  = PW'(rom_q);
  assign amp_x  = PW'({1'b0, amp_c});
  assign prod   = rom_x * amp_x;
  assign da_nxt = DATA_W'(PW'(MIDSCALE) + (prod >>> 7));

  sine_rom #(
    .AW (LUT_AW),
    .DW (DATA_W)
  ) u_rom (
    .clk   (clk),
    .reset (reset),
    .en    (tick),
    .clr   (rom_clr),
    .addr  (acc[PHASE_W-1 -: LUT_AW]),
    .q     (rom_q)
  );

  // free-running sample divider and DAC clock
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      DA0_CLK     <= 1'b0;
      sample_tick <= 1'b0;
    end else begin
      cnt         <= cnt_nxt;
      DA0_CLK     <= (cnt_nxt >= CW'(DIV_N / 2));
      sample_tick <= tick;
    end
  end

  // state register; running tracks the registered state
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      running <= 1'b0;
    end else begin
      state   <= state_nxt;
      running <= (state_nxt != IDLE);
    end
  end

  // mode transitions, evaluated only on sample ticks
  always_comb begin
    state_nxt = state;
    if (tick) begin
      unique case (state)
        IDLE: begin
          if (enable) state_nxt = RUN;
        end
        RUN: begin
          if (!enable) state_nxt = STOP_PEND;
        end
        STOP_PEND: begin
          if (enable) state_nxt = RUN;
          else if (carry || fw_active == '0)
            state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // tuning word shadow/active pair and phase/output stages
  always_ff @(posedge clk) begin
    if (reset) begin
      fw_shadow <= '0;
      fw_active <= '0;
      acc       <= '0;
      DA0       <= DATA_W'(MIDSCALE);
    end else begin
      if (fword_load) fw_shadow <= fword_in;
      if (tick) begin
        fw_active <= fw_shadow;
        if (state == IDLE) begin
          acc <= '0;
          DA0 <= DATA_W'(MIDSCALE);
        end else begin
          acc <= acc_sum[PHASE_W-1:0];
          DA0 <= da_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_dds_dac_tx.sv
// Directed bench for dds_dac_tx with a sample scoreboard.
// Expected samples come from a spec-level model using $sin.
module tb_dds_dac_tx;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_STOP = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [31:0] fword_in;
  logic        fword_load;
  logic [7:0]  amp;
  logic [7:0]  DA0;
  logic        DA0_CLK;
  logic        sample_tick;
  logic        running;

  int          vec = 0;
  int          err = 0;
  int          q[$];
  int          m_st;
  logic [31:0] m_acc;
  logic [31:0] m_act;
  logic [31:0] m_shd;

  always #5 clk = ~clk;

  dds_dac_tx #(
    .PHASE_W (32),
    .LUT_AW  (8),
    .DATA_W  (8),
    .DIV_N   (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .fword_in    (fword_in),
    .fword_load  (fword_load),
    .amp         (amp),
    .DA0         (DA0),
    .DA0_CLK     (DA0_CLK),
    .sample_tick (sample_tick),
    .running     (running)
  );

  function automatic int rom_ref(input logic [31:0] ph);
    real a;
    a = 6.283185307179586 * real'(ph[31:24]) / 256.0;
    return int'(127.0 * $sin(a));
  endfunction

  function automatic int da_ref(input int r, input logic [7:0] a);
    int c;
    c = (a > 8'd128) ? 128 : int'(a);
    return 128 + ((r * c) >>> 7);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_sample();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (sample_tick !== 1'b1 && n < 8);
    chk("sample_tick_seen", 32'(sample_tick), 32'd1);
  endtask

  task automatic model_reset();
    m_st  = M_IDLE;
    m_acc = '0;
    m_act = '0;
    m_shd = '0;
    q.delete();
    q.push_back(0);
  endtask

  task automatic load_fw(input logic [31:0] w);
    if (DA0_CLK !== 1'b0) @(negedge clk);
    fword_in   = w;
    fword_load = 1'b1;
    @(negedge clk);
    fword_load = 1'b0;
    m_shd      = w;
  endtask

  task automatic run_tick(input bit ld, input logic [31:0] w);
    int          exp_da;
    logic [32:0] sum;
    bit          en;
    if (ld && DA0_CLK !== 1'b1) @(negedge clk);
    if (ld) begin
      fword_in   = w;
      fword_load = 1'b1;
    end
    en = enable;
    if (m_st == M_IDLE) begin
      exp_da = 128;
      m_acc  = '0;
      q.delete();
      q.push_back(0);
      if (en) m_st = M_RUN;
    end else begin
      exp_da = da_ref(q.pop_front(), amp);
      q.push_back(rom_ref(m_acc));
      sum   = {1'b0, m_acc} + {1'b0, m_act};
      m_acc = sum[31:0];
      if (m_st == M_RUN) begin
        if (!en) m_st = M_STOP;
      end else if (en) begin
        m_st = M_RUN;
      end else if (sum[32] || m_act == 32'd0) begin
        m_st = M_IDLE;
      end
    end
    m_act = m_shd;
    if (ld) m_shd = w;
    wait_sample();
    fword_load = 1'b0;
    chk("DA0", 32'(DA0), exp_da);
    chk("running", 32'(running), 32'(m_st != M_IDLE));
    chk("DA0_CLK_low", 32'(DA0_CLK), 32'd0);
  endtask

  initial begin
    reset      = 1'b1;
    enable     = 1'b0;
    fword_in   = '0;
    fword_load = 1'b0;
    amp        = 8'd128;
    model_reset();
    repeat (5) @(negedge clk);
    chk("rst_DA0", 32'(DA0), 32'd128);
    chk("rst_DA0_CLK", 32'(DA0_CLK), 32'd0);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_sample_tick", 32'(sample_tick), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("div_DA0_CLK", 32'(DA0_CLK), 32'(i % 2 == 0));
      chk("div_tick", 32'(sample_tick), 32'(i % 2 == 1));
      chk("idle_DA0", 32'(DA0), 32'd128);
    end

    load_fw(32'h0100_0000);
    amp    = 8'd128;
    enable = 1'b1;
    repeat (100) run_tick(1'b0, '0);
    enable = 1'b0;
    repeat (170) run_tick(1'b0, '0);

    amp    = 8'd64;
    enable = 1'b1;
    repeat (260) run_tick(1'b0, '0);
    amp = 8'd200;
    repeat (100) run_tick(1'b0, '0);
    enable = 1'b0;
    repeat (20) run_tick(1'b0, '0);
    enable = 1'b1;
    repeat (20) run_tick(1'b0, '0);

    amp = 8'd128;
    load_fw(32'd8589935);
    repeat (30) run_tick(1'b0, '0);
    run_tick(1'b1, 32'd17179870);
    repeat (30) run_tick(1'b0, '0);

    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_DA0", 32'(DA0), 32'd128);
    chk("mid_rst_DA0_CLK", 32'(DA0_CLK), 32'd0);
    chk("mid_rst_tick", 32'(sample_tick), 32'd0);
    chk("mid_rst_running", 32'(running), 32'd0);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (2) run_tick(1'b0, '0);
    load_fw(32'h0100_0000);
    enable = 1'b1;
    repeat (40) run_tick(1'b0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
